capture_ctrl: RTL and testbench

//  Sequences sample capture for the logic analyzer: writes samples into a circular capture RAM and

---
 rtl/la_pkg.sv | 15 +
 rtl/circ_addr_cnt.sv | 49 ++++
 rtl/capture_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_capture_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM states and default geometry.
package la_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } cap_state_t;

    localparam int LA_ENTRIES = 32'd384;
    localparam int LA_AW      = 32'd9;
    localparam int LA_NCH     = 32'd5;

endpackage

// File: rtl/circ_addr_cnt.sv
// Circular RAM write-address counter: clears to 0, wraps ENTRIES-1 -> 0,
// and exposes the address of the most recent write as prev.
module circ_addr_cnt
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int AW      = LA_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] cur,
    output logic [AW-1:0] prev
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(ENTRIES - 1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] cur_r;
    logic [AW-1:0] prev_s;

    // Address register: clear has priority over increment, increment wraps at the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r <= ADDR_ZERO;
        end else if (clear) begin
            cur_r <= ADDR_ZERO;
        end else if (inc) begin
            cur_r <= (cur_r == ADDR_LAST) ? ADDR_ZERO : (cur_r + ADDR_ONE);
        end else begin
            cur_r <= cur_r;
        end
    end

    // Previous address with wrap, i.e. where the last write landed.
    always_comb begin
        if (cur_r == ADDR_ZERO) begin
            prev_s = ADDR_LAST;
        end else begin
            prev_s = cur_r - ADDR_ONE;
        end
    end

    assign cur  = cur_r;
    assign prev = prev_s;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills the circular capture RAM, arms the channel trigger
// blocks once enough pre-trigger samples are stored, counts post-trigger
// samples and reports completion with the final write address.
module capture_ctrl
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int AW      = LA_AW,
    parameter int NCH     = LA_NCH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_smpl,
    input  logic           run,
    input  logic           clr_done,
    input  logic [AW-1:0]  trig_posn,
    input  logic [NCH-1:0] chan_trig,
    input  logic           prot_trig,
    output logic           set_armed,
    output logic           we,
    output logic [AW-1:0]  waddr,
    output logic           triggered,
    output logic           capture_done,
    output logic [AW-1:0]  last_addr
);

    localparam logic [AW-1:0] ENT_MAX   = AW'(ENTRIES - 1);
    localparam logic [AW:0]   ENT_CNT   = (AW + 1)'(ENTRIES);
    localparam logic [AW-1:0] CNT_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] CNT_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   SCNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   SCNT_ONE  = {{AW{1'b0}}, 1'b1};

    cap_state_t    state_r, state_nxt_s;
    logic [AW:0]   smpl_cnt_r, smpl_cnt_nxt_s;
    logic [AW-1:0] post_cnt_r, post_cnt_nxt_s;
    logic [AW-1:0] posn_l_r, posn_l_nxt_s;
    logic [AW-1:0] last_addr_r, last_addr_nxt_s;
    logic          armed_r, armed_nxt_s;
    logic          trig_r, trig_nxt_s;
    logic          done_r, done_nxt_s;
    logic          addr_clr_s, addr_inc_s;
    logic          we_s;
    logic          trig_raw_s;
    logic [AW-1:0] cur_addr_s, prev_addr_s;
    logic [AW-1:0] posn_clamp_s;
    logic [AW:0]   arm_sum_s;

    circ_addr_cnt #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_addr (
        .clk   (clk),
        .rst   (rst),
        .clear (addr_clr_s),
        .inc   (addr_inc_s),
        .cur   (cur_addr_s),
        .prev  (prev_addr_s)
    );

    assign trig_raw_s = (&chan_trig) & prot_trig;
    assign arm_sum_s  = smpl_cnt_r + {1'b0, posn_l_r};

    // Post-trigger count cannot exceed the RAM depth minus one sample.
    always_comb begin
        if ({1'b0, trig_posn} >= ENT_CNT) begin
            posn_clamp_s = ENT_MAX;
        end else begin
            posn_clamp_s = trig_posn;
        end
    end

    // RAM write strobe: only while filling; a zero post count means no post writes at all.
    always_comb begin
        if (state_r == CAPT) begin
            we_s = en_smpl;
        end else if ((state_r == POST) && (posn_l_r != CNT_ZERO)) begin
            we_s = en_smpl;
        end else begin
            we_s = 1'b0;
        end
    end

    // Next-state and counter logic; run restarts the capture from any state.
    always_comb begin
        state_nxt_s     = state_r;
        smpl_cnt_nxt_s  = smpl_cnt_r;
        post_cnt_nxt_s  = post_cnt_r;
        posn_l_nxt_s    = posn_l_r;
        last_addr_nxt_s = last_addr_r;
        armed_nxt_s     = 1'b0;
        trig_nxt_s      = trig_r;
        done_nxt_s      = 1'b0;
        addr_clr_s      = 1'b0;
        addr_inc_s      = 1'b0;
        if (run) begin
            state_nxt_s    = CAPT;
            smpl_cnt_nxt_s = SCNT_ZERO;
            post_cnt_nxt_s = CNT_ZERO;
            posn_l_nxt_s   = posn_clamp_s;
            trig_nxt_s     = 1'b0;
            addr_clr_s     = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                CAPT: begin
                    if (en_smpl) begin
                        addr_inc_s = 1'b1;
                        if (smpl_cnt_r == ENT_CNT) begin
                            smpl_cnt_nxt_s = smpl_cnt_r;
                        end else begin
                            smpl_cnt_nxt_s = smpl_cnt_r + SCNT_ONE;
                        end
                    end else begin
                        smpl_cnt_nxt_s = smpl_cnt_r;
                    end
                    if (armed_r && trig_raw_s) begin
                        state_nxt_s    = POST;
                        post_cnt_nxt_s = CNT_ZERO;
                        trig_nxt_s     = 1'b1;
                        armed_nxt_s    = 1'b1;
                    end else begin
                        armed_nxt_s = (arm_sum_s >= ENT_CNT);
                    end
                end
                POST: begin
                    if (posn_l_r == CNT_ZERO) begin
                        state_nxt_s     = DONE;
                        last_addr_nxt_s = prev_addr_s;
                        done_nxt_s      = 1'b1;
                    end else if (en_smpl) begin
                        addr_inc_s = 1'b1;
                        if ((post_cnt_r + CNT_ONE) == posn_l_r) begin
                            state_nxt_s     = DONE;
                            last_addr_nxt_s = cur_addr_s;
                            done_nxt_s      = 1'b1;
                        end else begin
                            post_cnt_nxt_s = post_cnt_r + CNT_ONE;
                            armed_nxt_s    = 1'b1;
                        end
                    end else begin
                        armed_nxt_s = 1'b1;
                    end
                end
                DONE: begin
                    if (clr_done) begin
                        state_nxt_s     = IDLE;
                        trig_nxt_s      = 1'b0;
                        last_addr_nxt_s = CNT_ZERO;
                        addr_clr_s      = 1'b1;
                    end else begin
                        done_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            smpl_cnt_r  <= SCNT_ZERO;
            post_cnt_r  <= CNT_ZERO;
            posn_l_r    <= CNT_ZERO;
            last_addr_r <= CNT_ZERO;
            armed_r     <= 1'b0;
            trig_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            smpl_cnt_r  <= smpl_cnt_nxt_s;
            post_cnt_r  <= post_cnt_nxt_s;
            posn_l_r    <= posn_l_nxt_s;
            last_addr_r <= last_addr_nxt_s;
            armed_r     <= armed_nxt_s;
            trig_r      <= trig_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign set_armed    = armed_r;
    assign we           = we_s;
    assign waddr        = cur_addr_s;
    assign triggered    = trig_r;
    assign capture_done = done_r;
    assign last_addr    = last_addr_r;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed capture scenarios plus a
// randomized phase, all compared cycle by cycle against a write-count model.
module tb_capture_ctrl;

    localparam int E   = 384;
    localparam int AW  = 9;
    localparam int NCH = 5;

    logic           clk;
    logic           rst;
    logic           en_smpl;
    logic           run;
    logic           clr_done;
    logic [AW-1:0]  trig_posn;
    logic [NCH-1:0] chan_trig;
    logic           prot_trig;
    logic           set_armed;
    logic           we;
    logic [AW-1:0]  waddr;
    logic           triggered;
    logic           capture_done;
    logic [AW-1:0]  last_addr;

    capture_ctrl #(.ENTRIES(E), .AW(AW), .NCH(NCH)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_smpl      (en_smpl),
        .run          (run),
        .clr_done     (clr_done),
        .trig_posn    (trig_posn),
        .chan_trig    (chan_trig),
        .prot_trig    (prot_trig),
        .set_armed    (set_armed),
        .we           (we),
        .waddr        (waddr),
        .triggered    (triggered),
        .capture_done (capture_done),
        .last_addr    (last_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 pre-trigger, 2 post-trigger, 3 done.
    // Addresses are derived from the total number of writes modulo the depth.
    int m_phase = 0;
    int m_wr    = 0;
    int m_post  = 0;
    int m_tp    = 0;
    int m_last  = 0;
    bit m_armed = 0;
    bit m_trig  = 0;
    bit m_done  = 0;
    bit m_valid = 0;

    // Observation counters for the directed scenarios.
    int wr_obs, post_obs, arm_at_wr, cyc, arm_cyc, trig_cyc, div;
    bit armed_seen, trig_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_we();
        return en_smpl && ((m_phase == 1) || ((m_phase == 2) && (m_tp != 0)));
    endfunction

    task automatic model_finish();
        m_phase = 3;
        m_done  = 1;
        m_armed = 0;
        m_last  = (m_wr + E - 1) % E;
    endtask

    task automatic model_step();
        int stored;
        if (rst) begin
            m_phase = 0; m_wr = 0; m_post = 0; m_tp = 0; m_last = 0;
            m_armed = 0; m_trig = 0; m_done = 0; m_valid = 1;
        end else if (!m_valid) begin
            m_valid = 0;
        end else if (run) begin
            m_phase = 1; m_wr = 0; m_post = 0;
            m_tp    = (int'(trig_posn) >= E) ? E - 1 : int'(trig_posn);
            m_armed = 0; m_trig = 0; m_done = 0;
        end else begin
            case (m_phase)
                1: begin
                    stored = (m_wr < E) ? m_wr : E;
                    if (m_armed && (&chan_trig) && prot_trig) begin
                        m_phase = 2; m_post = 0; m_trig = 1;
                    end else begin
                        m_armed = (stored + m_tp >= E);
                    end
                    if (en_smpl) m_wr++;
                end
                2: begin
                    if (m_tp == 0) begin
                        model_finish();
                    end else if (en_smpl) begin
                        m_wr++;
                        m_post++;
                        if (m_post == m_tp) model_finish();
                    end
                end
                3: begin
                    if (clr_done) begin
                        m_phase = 0; m_trig = 0; m_done = 0; m_wr = 0; m_last = 0;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock: drive pulses at the falling edge, check we, advance model, check registers.
    task automatic tick(input logic e, input logic r, input logic c);
        @(negedge clk);
        en_smpl  = e;
        run      = r;
        clr_done = c;
        #1;
        if (m_valid) chk("we", we, model_we());
        if (we === 1'b1) begin
            wr_obs++;
            if (triggered === 1'b1) post_obs++;
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (m_valid) begin
            chk("set_armed", set_armed, m_armed);
            chk("triggered", triggered, m_trig);
            chk("capture_done", capture_done, m_done);
            chk("waddr", waddr, m_wr % E);
            chk("last_addr", last_addr, m_last);
        end
        if (set_armed === 1'b1 && !armed_seen) begin
            armed_seen = 1; arm_at_wr = wr_obs; arm_cyc = cyc;
        end
        if (triggered === 1'b1 && !trig_seen) begin
            trig_seen = 1; trig_cyc = cyc;
        end
    endtask

    task automatic clear_obs();
        wr_obs = 0; post_obs = 0; arm_at_wr = -1; armed_seen = 0; trig_seen = 0;
        arm_cyc = 0; trig_cyc = 0; div = 0;
    endtask

    task automatic start_capture(input int tp);
        trig_posn = AW'(tp);
        tick(1'b0, 1'b1, 1'b0);
        clear_obs();
    endtask

    // Sample every 4th clock until done; chan_trig goes all-ones once trig_at writes are stored.
    task automatic sample_until_done(input int budget, input int trig_at);
        for (int i = 0; i < budget && capture_done !== 1'b1; i++) begin
            if (trig_at >= 0 && wr_obs >= trig_at) chan_trig = {NCH{1'b1}};
            tick(div == 3, 1'b0, 1'b0);
            div = (div + 1) % 4;
        end
        chk("done_reached", capture_done, 1'b1);
    endtask

    initial begin
        rst = 1'b1; en_smpl = 1'b0; run = 1'b0; clr_done = 1'b0;
        trig_posn = '0; chan_trig = '0; prot_trig = 1'b1;
        cyc = 0;
        clear_obs();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_set_armed", set_armed, 1'b0);
        chk("rst_triggered", triggered, 1'b0);
        chk("rst_done", capture_done, 1'b0);
        chk("rst_waddr", waddr, 0);
        chk("rst_last_addr", last_addr, 0);
        chk("rst_we", we, 1'b0);

        // Arming point, with the trigger held off until after arming.
        chan_trig = '0;
        start_capture(100);
        sample_until_done(5000, 300);
        chk("t1_arm_wr", arm_at_wr, 284);
        chk("t1_post_wr", post_obs, 100);
        chk("t1_total_wr", wr_obs, 400);
        chk("t1_last", last_addr, (300 + 100 - 1) % E);

        // Trigger present from run: accepted right after arming.
        tick(1'b0, 1'b0, 1'b1);
        chan_trig = {NCH{1'b1}};
        start_capture(100);
        sample_until_done(5000, 0);
        chk("t2_arm_wr", arm_at_wr, 284);
        chk("t2_trig_lag", trig_cyc - arm_cyc, 1);
        chk("t2_post_wr", post_obs, 100);
        chk("t2_total_wr", wr_obs, 384);
        chk("t2_last", last_addr, 383);

        // Late trigger: address wraps.
        tick(1'b0, 1'b0, 1'b1);
        chan_trig = '0;
        start_capture(100);
        sample_until_done(8000, 500);
        chk("t3_total_wr", wr_obs, 600);
        chk("t3_post_wr", post_obs, 100);
        chk("t3_last", last_addr, 215);

        // Zero post-trigger count.
        tick(1'b0, 1'b0, 1'b1);
        chan_trig = {NCH{1'b1}};
        start_capture(0);
        sample_until_done(5000, 0);
        chk("t4a_post_wr", post_obs, 0);
        chk("t4a_total_wr", wr_obs, 384);
        chk("t4a_last", last_addr, (wr_obs + E - 1) % E);

        // Oversized post-trigger count clamps to depth-1.
        tick(1'b0, 1'b0, 1'b1);
        start_capture(400);
        sample_until_done(5000, 0);
        chk("t4b_arm_wr", arm_at_wr, 1);
        chk("t4b_post_wr", post_obs, 383);
        chk("t4b_last", last_addr, 383);

        // Restart in the middle of the post-trigger phase.
        tick(1'b0, 1'b0, 1'b1);
        start_capture(100);
        for (int i = 0; i < 4000 && post_obs < 10; i++) begin
            tick(div == 3, 1'b0, 1'b0);
            div = (div + 1) % 4;
        end
        chk("t5_post_reached", post_obs, 10);
        start_capture(100);
        chk("t5_trig_clr", triggered, 1'b0);
        chk("t5_armed_clr", set_armed, 1'b0);
        chk("t5_waddr_clr", waddr, 0);
        sample_until_done(5000, 0);
        chk("t5_post_wr", post_obs, 100);
        chk("t5_last", last_addr, 383);

        // Reset in the middle of pre-trigger capture.
        tick(1'b0, 1'b0, 1'b1);
        chan_trig = '0;
        start_capture(50);
        for (int i = 0; i < 60; i++) begin
            tick(div == 3, 1'b0, 1'b0);
            div = (div + 1) % 4;
        end
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t5r_waddr", waddr, 0);
        chk("t5r_armed", set_armed, 1'b0);
        chk("t5r_done", capture_done, 1'b0);
        chan_trig = {NCH{1'b1}};
        start_capture(100);
        sample_until_done(5000, 0);
        chk("t5r_last", last_addr, 383);

        // run and clr_done together in DONE: run wins.
        tick(1'b0, 1'b1, 1'b1);
        clear_obs();
        chk("t6_done_clr", capture_done, 1'b0);
        chk("t6_trig_clr", triggered, 1'b0);
        chk("t6_waddr", waddr, 0);
        sample_until_done(5000, 0);
        chk("t6_last", last_addr, 383);
        tick(1'b0, 1'b0, 1'b1);
        chk("t6_idle_done", capture_done, 1'b0);
        chk("t6_idle_trig", triggered, 1'b0);
        chk("t6_idle_armed", set_armed, 1'b0);
        chk("t6_idle_waddr", waddr, 0);
        chk("t6_idle_last", last_addr, 0);
        tick(1'b1, 1'b0, 1'b0);

        // Randomized phase checked against the model every cycle.
        for (int i = 0; i < 6000; i++) begin
            trig_posn = AW'($urandom_range(0, 450));
            chan_trig = ($urandom_range(0, 7) == 0) ? {NCH{1'b1}} : NCH'($urandom);
            prot_trig = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 2999) == 0);
            tick($urandom_range(0, 1) == 1,
                 $urandom_range(0, 399) == 0,
                 $urandom_range(0, 39) == 0);
        end
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
